// File: rtl/multi_timer.sv
// multi_timer: NUM_CH-channel bus timer with a shared prescaled tick, per-channel period,
// periodic/one-shot modes, W1C status and per-channel level interrupt with acknowledge.
// Latency: register writes take effect on the addressed edge; reads drive BUS_DATA the following cycle.
// Backpressure: none; the bus is a fixed-timing shared bus, and BUS_DATA is driven only in the read-return cycle.
//
// Ports:
//   CLK                   system clock
//   RESET                 asynchronous active-high reset
//   BUS_DATA   [7:0]      shared data bus (input on writes, driven for one cycle after a read)
//   BUS_ADDR   [7:0]      bus address; channel c at BASE_ADDR+4c .. +3 (CTRL, PERIOD, COUNT, STATUS)
//   BUS_WE                1 = processor write, 0 = read
//   BUS_INTERRUPTS_RAISE  per-channel level interrupt, held until acknowledged
//   BUS_INTERRUPTS_ACK    per-channel one-cycle acknowledge pulse
module multi_timer #(
   parameter int         NUM_CH      = 2,
   parameter logic [7:0] BASE_ADDR   = 8'hF0,
   parameter int         CLK_FREQ_HZ = 50_000_000,
   parameter int         TICK_HZ     = 1000
) (
   input  logic              CLK,
   input  logic              RESET,
   inout  wire  [7:0]        BUS_DATA,
   input  logic [7:0]        BUS_ADDR,
   input  logic              BUS_WE,
   output logic [NUM_CH-1:0] BUS_INTERRUPTS_RAISE,
   input  logic [NUM_CH-1:0] BUS_INTERRUPTS_ACK
);

   localparam int PRESCALE = CLK_FREQ_HZ / TICK_HZ;
   localparam int PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam int SPAN     = 4 * NUM_CH;

   // ---------------------------------------------------------------
   // Shared prescaler: free-running, untouched by any register write
   // ---------------------------------------------------------------
   logic [PW-1:0] r_presc;
   logic          w_tick;

   assign w_tick = (r_presc == PW'(PRESCALE - 1));

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET)       r_presc <= '0;
      else if (w_tick) r_presc <= '0;
      else             r_presc <= r_presc + 1'b1;
   end

   // ---------------------------------------------------------------
   // Address decode. The 9-bit difference carries a borrow so that
   // addresses below BASE_ADDR never alias into the window.
   // ---------------------------------------------------------------
   logic [8:0] w_off9;
   logic       w_hit;
   logic [2:0] w_ch;
   logic [1:0] w_reg;

   assign w_off9 = {1'b0, BUS_ADDR} - {1'b0, BASE_ADDR};
   assign w_hit  = !w_off9[8] && (w_off9 < 9'(SPAN));
   assign w_ch   = w_off9[4:2];
   assign w_reg  = w_off9[1:0];

   logic [7:0]        w_rd_val [8];
   logic [NUM_CH-1:0] w_raise;

   // ---------------------------------------------------------------
   // Channels
   // ---------------------------------------------------------------
   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      logic [2:0] r_ctrl;     // [0] EN, [1] ONESHOT, [2] IRQ_EN
      logic [7:0] r_period;
      logic [7:0] r_count;
      logic       r_evt;
      logic       r_ovr;
      logic       r_raise;

      logic       w_sel;
      logic       w_wr_ctrl;
      logic       w_wr_per;
      logic       w_wr_stat;
      logic       w_run;
      logic       w_evt_now;
      logic       w_irq_evt;
      logic       w_ack;
      logic [7:0] w_val;

      assign w_sel     = w_hit && (w_ch == 3'(c));
      assign w_wr_ctrl = w_sel && BUS_WE && (w_reg == 2'd0);
      assign w_wr_per  = w_sel && BUS_WE && (w_reg == 2'd1);
      assign w_wr_stat = w_sel && BUS_WE && (w_reg == 2'd3);
      assign w_ack     = BUS_INTERRUPTS_ACK[c];

      // A PERIOD write on a tick edge swallows that tick: count restarts, no event.
      assign w_run     = w_tick && r_ctrl[0] && !w_wr_per;
      assign w_evt_now = w_run && (r_count == r_period);
      assign w_irq_evt = w_evt_now && r_ctrl[2];

      always_ff @(posedge CLK or posedge RESET) begin
         if (RESET) begin
            r_ctrl   <= 3'b000;
            r_period <= 8'd99;
            r_count  <= 8'd0;
            r_evt    <= 1'b0;
            r_ovr    <= 1'b0;
            r_raise  <= 1'b0;
         end else begin
            // COUNT: PERIOD write and an EN 0->1 write both restart from 0
            if (w_wr_per)
               r_count <= 8'd0;
            else if (w_wr_ctrl && !r_ctrl[0] && BUS_DATA[0])
               r_count <= 8'd0;
            else if (w_run)
               r_count <= w_evt_now ? 8'd0 : r_count + 8'd1;

            if (w_wr_per)
               r_period <= BUS_DATA;

            // A CTRL write on the same edge overrides the one-shot self-disable
            if (w_wr_ctrl)
               r_ctrl <= BUS_DATA[2:0];
            else if (w_evt_now && r_ctrl[1])
               r_ctrl[0] <= 1'b0;

            // Write-1-to-clear; a coincident event wins for the bit it sets
            r_evt <= (r_evt & ~(w_wr_stat & BUS_DATA[0])) | w_evt_now;
            r_ovr <= (r_ovr & ~(w_wr_stat & BUS_DATA[1]))
                   | (w_irq_evt & r_raise & ~w_ack);

            // An interrupting event beats a same-edge acknowledge
            if (w_irq_evt)  r_raise <= 1'b1;
            else if (w_ack) r_raise <= 1'b0;
         end
      end

      always_comb begin
         w_val = 8'h00;
         case (w_reg)
            2'd0:    w_val = {5'b00000, r_ctrl};
            2'd1:    w_val = r_period;
            2'd2:    w_val = r_count;
            default: w_val = {6'b000000, r_ovr, r_evt};
         endcase
      end

      assign w_rd_val[c] = w_val;
      assign w_raise[c]  = r_raise;
   end

   // Unpopulated channel slots keep the 3-bit channel index in range
   for (genvar c = NUM_CH; c < 8; c++) begin : g_pad
      assign w_rd_val[c] = 8'h00;
   end

   assign BUS_INTERRUPTS_RAISE = w_raise;

   // ---------------------------------------------------------------
   // Read return: capture on the addressed edge, drive for one cycle
   // ---------------------------------------------------------------
   logic       r_rd_vld;
   logic [7:0] r_rd_dat;
   logic       w_rd_req;

   assign w_rd_req = w_hit && !BUS_WE;

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         r_rd_vld <= 1'b0;
         r_rd_dat <= 8'h00;
      end else begin
         r_rd_vld <= w_rd_req;
         if (w_rd_req)
            r_rd_dat <= w_rd_val[w_ch];
      end
   end

   assign BUS_DATA = r_rd_vld ? r_rd_dat : 8'hzz;

endmodule
